// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - operand-mux select encodings, FSM state type and forwarding match helper.
package hazard_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
  function automatic logic fwd_hit(
    input logic [REG_W-1:0] rd,
    input logic             we,
    input logic [REG_W-1:0] rs
  );
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_sel.sv
// rtl/forward_sel.sv - select for one execute-stage operand mux; memory stage wins over writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (fwd_hit(rd_m, reg_write_m, rs)) begin
      sel = FWD_MEM;
    end else if (fwd_hit(rd_w, reg_write_w, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush generation, data-memory wait FSM with watchdog and stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             mem_read_e,
  input  logic             pc_src_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mem_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_PRE = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              mem_stall;
  logic              load_use;
  logic              any_stall;

  forward_sel u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_a)
  );

  forward_sel u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_b)
  );

  assign mem_stall = dmem_req_m && !dmem_ready;
  assign load_use  = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority is memory wait, then branch, then load-use; everything is held low during reset.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    if (!rst) begin
      forward_a_e = sel_a;
      forward_b_e = sel_b;
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign any_stall = stall_f || stall_d || stall_e || stall_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready || !dmem_req_m) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign mem_busy = (state == MEM_WAIT);

  // The watchdog only reports; the pipeline stays stalled for as long as memory is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_stall) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt >= WAIT_PRE) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (any_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with a 32-bit and a 4-bit stall counter instance.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 16;

  localparam logic [9:0] E_NONE = 10'b00_00_0000_00;
  localparam logic [9:0] E_MEMW = 10'b00_00_1111_00;
  localparam logic [9:0] E_LU   = 10'b00_00_1100_01;
  localparam logic [9:0] E_BR   = 10'b00_00_0000_11;

  typedef struct packed {
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic       mem_read_e;
    logic       pc_src_e;
    logic [4:0] rd_m;
    logic       reg_write_m;
    logic [4:0] rd_w;
    logic       reg_write_w;
    logic       dmem_req_m;
    logic       dmem_ready;
  } stim_t;

  logic        clk;
  logic        rst;
  stim_t       s;

  logic [1:0]  forward_a_e, forward_b_e, forward_a_e4, forward_b_e4;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic        stall_f4, stall_d4, stall_e4, stall_m4, flush_d4, flush_e4;
  logic        mem_busy, mem_timeout, mem_busy4, mem_timeout4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall_cycles4;
  logic [9:0]  got, got4;

  logic [9:0]  exp_q[$];
  int          checks;
  int          errors;

  logic [31:0] m_cnt, p_cnt;
  logic [3:0]  m_cnt4, p_cnt4;
  logic        m_busy, p_busy, m_to, p_to;
  int          m_wait, p_wait;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(s.rs1_d), .rs2_d(s.rs2_d), .rs1_e(s.rs1_e), .rs2_e(s.rs2_e), .rd_e(s.rd_e),
    .mem_read_e(s.mem_read_e), .pc_src_e(s.pc_src_e),
    .rd_m(s.rd_m), .reg_write_m(s.reg_write_m), .rd_w(s.rd_w), .reg_write_w(s.reg_write_w),
    .dmem_req_m(s.dmem_req_m), .dmem_ready(s.dmem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_busy(mem_busy), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs1_d(s.rs1_d), .rs2_d(s.rs2_d), .rs1_e(s.rs1_e), .rs2_e(s.rs2_e), .rd_e(s.rd_e),
    .mem_read_e(s.mem_read_e), .pc_src_e(s.pc_src_e),
    .rd_m(s.rd_m), .reg_write_m(s.reg_write_m), .rd_w(s.rd_w), .reg_write_w(s.reg_write_w),
    .dmem_req_m(s.dmem_req_m), .dmem_ready(s.dmem_ready),
    .forward_a_e(forward_a_e4), .forward_b_e(forward_b_e4),
    .stall_f(stall_f4), .stall_d(stall_d4), .stall_e(stall_e4), .stall_m(stall_m4),
    .flush_d(flush_d4), .flush_e(flush_e4),
    .mem_busy(mem_busy4), .mem_timeout(mem_timeout4), .stall_cycles(stall_cycles4)
  );

  assign got  = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};
  assign got4 = {forward_a_e4, forward_b_e4, stall_f4, stall_d4, stall_e4, stall_m4, flush_d4, flush_e4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic stim_t mk(
    input logic [4:0] rs1_d, input logic [4:0] rs2_d, input logic [4:0] rs1_e,
    input logic [4:0] rs2_e, input logic [4:0] rd_e, input logic mr, input logic pc,
    input logic [4:0] rd_m, input logic wm, input logic [4:0] rd_w, input logic ww,
    input logic req, input logic rdy
  );
    return '{rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mr, pc, rd_m, wm, rd_w, ww, req, rdy};
  endfunction

  // Drives one cycle at the falling edge, pushes the expected combinational outputs and
  // advances the reference model of the registered outputs for the following rising edge.
  task automatic drive_row(input stim_t st, input logic r, input logic [9:0] e);
    logic ms;
    logic any;
    @(negedge clk);
    m_cnt = p_cnt; m_cnt4 = p_cnt4; m_busy = p_busy; m_to = p_to; m_wait = p_wait;
    rst = r;
    s   = st;
    if (r) begin
      m_cnt = '0; m_cnt4 = '0; m_busy = 1'b0; m_to = 1'b0; m_wait = 0;
    end
    exp_q.push_back(r ? E_NONE : e);
    ms     = st.dmem_req_m && !st.dmem_ready && !r;
    any    = !r && (|e[5:2]);
    p_cnt  = (any && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
    p_cnt4 = (any && m_cnt4 != 4'hF) ? m_cnt4 + 4'd1 : m_cnt4;
    p_busy = ms;
    p_to   = m_to || (ms && (m_wait + 1 >= TIMEOUT));
    p_wait = ms ? ((m_wait < TIMEOUT) ? m_wait + 1 : m_wait) : 0;
  endtask

  task automatic test_reset();
    stim_t sq[$];
    logic  e;
    logic [9:0] ev;
    sq.push_back(mk(5'd7, 5'd0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0));
    sq.push_back(mk(5'd7, 5'd0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0));
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      e = (i < 2);
      drive_row(sq[i], e, E_NONE);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL reset_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL reset_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
      checks++;
      if ({mem_busy, mem_busy4, mem_timeout, mem_timeout4} !== 4'b0000) begin
        errors++; $display("FAIL reset_regs row %0d got busy %b%b timeout %b%b exp 0", i, mem_busy, mem_busy4, mem_timeout, mem_timeout4);
      end
    end
  endtask

  task automatic test_forwarding();
    stim_t      sq[$];
    logic [9:0] eq[$];
    logic [9:0] ev;
    sq.push_back(mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b10_00_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b01_00_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b00_00_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b00_00_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b10_01_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b10_10_000000);
    sq.push_back(mk(5'd0, 5'd0, 5'd31, 5'd30, 5'd0, 1'b0, 1'b0, 5'd31, 1'b0, 5'd30, 1'b1, 1'b0, 1'b0)); eq.push_back(10'b00_01_000000);
    for (int i = 0; i < sq.size(); i++) begin
      drive_row(sq[i], 1'b0, eq[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL fwd_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL fwd_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t      sq[$];
    logic [9:0] eq[$];
    logic [9:0] ev;
    sq.push_back(mk(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_LU);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd8, 5'd2, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_BR);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    for (int i = 0; i < sq.size(); i++) begin
      drive_row(sq[i], 1'b0, eq[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL lu_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL lu_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      errors++; $display("FAIL lu_total got %0d exp 1", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    stim_t      sq[$];
    logic [9:0] eq[$];
    logic [9:0] ev;
    logic [31:0] base;
    base = m_cnt;
    for (int k = 0; k < 3; k++) begin
      sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); eq.push_back(E_MEMW);
    end
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); eq.push_back(E_MEMW);
    sq.push_back(mk(5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); eq.push_back(E_BR);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    for (int i = 0; i < sq.size(); i++) begin
      drive_row(sq[i], 1'b0, eq[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL memw_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL memw_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
      checks++;
      if ({mem_busy, mem_busy4} !== {m_busy, m_busy}) begin
        errors++; $display("FAIL memw_busy row %0d got %b%b exp %b", i, mem_busy, mem_busy4, m_busy);
      end
      checks++;
      if ({mem_timeout, mem_timeout4} !== 2'b00) begin
        errors++; $display("FAIL memw_timeout row %0d got %b%b exp 0", i, mem_timeout, mem_timeout4);
      end
      if (i == 4) begin
        checks++;
        if (stall_cycles !== base + 32'd3) begin
          errors++; $display("FAIL memw_total got %0d exp %0d", stall_cycles, base + 32'd3);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t      sq[$];
    logic [9:0] eq[$];
    logic [9:0] ev;
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); eq.push_back(E_NONE);
    sq.push_back(mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1)); eq.push_back(E_LU);
    sq.push_back(mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_LU);
    sq.push_back(mk(5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0)); eq.push_back(10'b10_10_1111_00);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); eq.push_back(E_NONE);
    for (int i = 0; i < sq.size(); i++) begin
      drive_row(sq[i], 1'b0, eq[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL b2b_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL b2b_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
      checks++;
      if ({mem_busy, mem_busy4} !== {m_busy, m_busy}) begin
        errors++; $display("FAIL b2b_busy row %0d got %b%b exp %b", i, mem_busy, mem_busy4, m_busy);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t      sq[$];
    logic       rq[$];
    logic [9:0] eq[$];
    logic [9:0] ev;
    for (int k = 0; k < 20; k++) begin
      sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0)); rq.push_back(1'b0); eq.push_back(E_MEMW);
    end
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); rq.push_back(1'b0); eq.push_back(E_NONE);
    sq.push_back(mk(5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0)); rq.push_back(1'b0); eq.push_back(10'b10_00_1111_00);
    sq.push_back(mk(5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0)); rq.push_back(1'b1); eq.push_back(E_NONE);
    sq.push_back(mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0)); rq.push_back(1'b0); eq.push_back(E_NONE);
    for (int i = 0; i < sq.size(); i++) begin
      drive_row(sq[i], rq[i], eq[i]);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL to_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL to_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
      checks++;
      if ({mem_busy, mem_busy4} !== {m_busy, m_busy}) begin
        errors++; $display("FAIL to_busy row %0d got %b%b exp %b", i, mem_busy, mem_busy4, m_busy);
      end
      checks++;
      if ({mem_timeout, mem_timeout4} !== {m_to, m_to}) begin
        errors++; $display("FAIL to_timeout row %0d got %b%b exp %b", i, mem_timeout, mem_timeout4, m_to);
      end
      if (i == 15 || i == 16) begin
        checks++;
        if (mem_timeout !== (i == 16)) begin
          errors++; $display("FAIL to_edge row %0d got %b exp %b", i, mem_timeout, (i == 16));
        end
      end
    end
  endtask

  task automatic test_saturation();
    stim_t sq;
    logic [9:0] ev;
    sq = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 21; i++) begin
      drive_row(sq, 1'b0, (i < 20) ? E_MEMW : E_NONE);
      if (i == 19) sq = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      ev = exp_q.pop_front();
      checks++;
      if ({got, got4} !== {ev, ev}) begin
        errors++; $display("FAIL sat_comb row %0d got %b/%b exp %b", i, got, got4, ev);
      end
      checks++;
      if (stall_cycles !== m_cnt || stall_cycles4 !== m_cnt4) begin
        errors++; $display("FAIL sat_cnt row %0d got %0d/%0d exp %0d/%0d", i, stall_cycles, stall_cycles4, m_cnt, m_cnt4);
      end
    end
    checks++;
    if (stall_cycles4 !== 4'hF || stall_cycles !== 32'd20) begin
      errors++; $display("FAIL sat_final got %h/%0d exp f/20", stall_cycles4, stall_cycles);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    s      = '0;
    m_cnt = '0; m_cnt4 = '0; m_busy = 1'b0; m_to = 1'b0; m_wait = 0;
    p_cnt = '0; p_cnt4 = '0; p_busy = 1'b0; p_to = 1'b0; p_wait = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It generates the 2-bit select inputs for the two execute-stage 3-to-1 operand muxes (forwarding). It also generates stall and flush controls for the fetch, decode, execute and memory pipeline registers. It sequences a data-memory wait handshake with a timeout watchdog and a saturating stall-cycle performance counter. It sits beside the datapath and drives only control; no data passes through it.

## Interface
- TIMEOUT, 16: consecutive not-ready memory cycles that set `mem_timeout` (≥2).
- CNT_W, 32: width of `stall_cycles`.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d  in  5  decode-stage source register indices.
- rs1_e, rs2_e, rd_e  in  5  execute-stage source and destination indices.
- mem_read_e  in  1  the execute-stage instruction is a load.
- pc_src_e  in  1  branch taken or jump resolved in execute.
- rd_m  in  5; reg_write_m  in  1  memory-stage destination and write enable.
- rd_w  in  5; reg_write_w  in  1  writeback-stage destination and write enable.
- dmem_req_m  in  1  memory-stage access valid.
- dmem_ready  in  1  data memory completes the access this cycle.
- forward_a_e, forward_b_e  out  2  operand mux selects.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register.
- flush_d, flush_e  out  1  clear the corresponding register to a bubble.
- mem_busy  out  1  FSM is in MEM_WAIT.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- **Forwarding** (combinational, per operand; shown for `rs1_e`):
  - Output 2'b10 (memory-stage result) if `reg_write_m && rd_m!=0 && rd_m==rs1_e`.
  - Else 2'b01 (writeback result) if `reg_write_w && rd_w!=0 && rd_w==rs1_e`.
  - Else 2'b00 (register file).
  - Memory-stage forwarding wins over writeback. 2'b11 is never driven.
- **Memory wait:** `mem_stall = dmem_req_m && !dmem_ready`.
  - When high, assert `stall_f`, `stall_d`, `stall_e` and `stall_m`.
  - Force `flush_d` and `flush_e` to 0.
- **Branch:** when `pc_src_e` is high and `mem_stall` is low, assert `flush_d` and `flush_e`. `stall_f` and `stall_d` are 0.
- **Load-use:** when `mem_read_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d)` and neither condition above holds, assert `stall_f`, `stall_d` and `flush_e`.
- **Priority:** memory wait > branch > load-use. A branch held during a memory wait flushes on the release cycle.
- **FSM** (states RUN, MEM_WAIT):
  - RUN→MEM_WAIT on a clock edge where `mem_stall` is high.
  - MEM_WAIT→RUN on an edge where `dmem_ready` is high or `dmem_req_m` is low.
  - `mem_busy` is high in MEM_WAIT.
- **Wait counter:**
  - Increments on each edge with `mem_stall` high, saturating at TIMEOUT.
  - Clears to 0 on any edge with `mem_stall` low.
  - `mem_timeout` sets on the edge where the counter reaches TIMEOUT. It clears only on `rst`.
  - The stall continues after timeout; the watchdog never releases the pipeline.
- **stall_cycles:** increments on each edge where any of `stall_f`/`stall_d`/`stall_e`/`stall_m` is high. It saturates at all-ones.

## Timing
- **Reset values:**
  - State RUN; wait counter 0.
  - `mem_timeout` 0, `mem_busy` 0, `stall_cycles` 0.
  - While `rst` is high, all stall, flush and forward outputs are forced to 0.
- All stall, flush and forward outputs are combinational (zero latency) from the same-cycle inputs.
- `mem_busy`, `mem_timeout` and `stall_cycles` are registered (one-cycle latency).
- **Timeout timing:** with TIMEOUT=16 and 16 consecutive `mem_stall` cycles (cycles 0–15), `mem_timeout` is high from cycle 16.
- **Simultaneous events:**
  - `dmem_ready` rising on the same cycle as the request: no stall, FSM stays in RUN.
  - Branch and load-use together: branch response only.
- **Reset mid-wait:** immediate return to RUN. Counters clear asynchronously.

## Structure
- Shared package `hazard_pkg`:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, matching the operand mux select encoding.
  - The state enum {RUN, MEM_WAIT}.
- Sub-module `forward_sel`: purely combinational, instantiated twice (operand A, operand B). Inputs: the source index plus the memory- and writeback-stage destination and write-enable.

## Test plan
- **Forwarding:** `rs1_e`=5, `rd_m`=5/`reg_write_m`=1, `rd_w`=5/`reg_write_w`=1 → `forward_a_e`=2'b10. With `reg_write_m`=0 → 2'b01. With `rd_m`=`rd_w`=0 → 2'b00.
- **Load-use:** `mem_read_e`=1, `rd_e`=7, `rs2_d`=7 → `stall_f`=`stall_d`=`flush_e`=1 for exactly that cycle; `stall_cycles` 0→1.
- **Branch vs. load-use:** branch and load-use hazard in the same cycle → `flush_d`=`flush_e`=1, `stall_f`=`stall_d`=0.
- **Memory wait:** `dmem_req_m`=1, `dmem_ready` low 3 cycles then high → all four stalls high for 3 cycles; `mem_busy` high for cycles 1–3; `mem_timeout` stays 0; `stall_cycles`=3.
- **Timeout:** `dmem_ready` held low 20 cycles → `mem_timeout`=1 from cycle 16; stalls remain high. Pulse `rst` mid-wait → all outputs 0, `mem_timeout`=0.
- **Saturation:** CNT_W=4, 20 stall cycles → `stall_cycles`=4'hF.
